// File: rtl/alu_divider.sv
// alu_divider: sequential unsigned restoring divider, one quotient bit per cycle.
// Define ALU_DIV_SIGNED_EN to add the signed_op port for two's-complement division.
module alu_divider #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
`ifdef ALU_DIV_SIGNED_EN
   input  logic             signed_op,
`endif
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_dvsr;
   logic             r_busy;
   logic             r_done;
   logic             r_dbz;
   logic             r_neg_q;
   logic             r_neg_r;

   logic             w_sop;
   logic             w_last;
   logic             w_dvs_zero;
   logic             w_neg;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH:0]   w_diff;
   logic [WIDTH-1:0] w_dvd_mag;
   logic [WIDTH-1:0] w_dvs_mag;

`ifdef ALU_DIV_SIGNED_EN
   assign w_sop = signed_op;
`else
   assign w_sop = 1'b0;
`endif

   assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
   assign w_dvs_zero = (divisor == '0);

   // Signed operands are divided as magnitudes; signs are restored on leaving DONE.
   assign w_dvd_mag = (w_sop && dividend[WIDTH-1]) ? (~dividend) + WIDTH'(1) : dividend;
   assign w_dvs_mag = (w_sop && divisor[WIDTH-1])  ? (~divisor) + WIDTH'(1)  : divisor;

   // Partial remainder < divisor, so the top bit of the WIDTH+1 difference is the borrow.
   assign w_shift = {r_rem, r_quo[WIDTH-1]};
   assign w_diff  = w_shift - {1'b0, r_dvsr};
   assign w_neg   = w_diff[WIDTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = w_dvs_zero ? S_DONE : S_RUN;
         S_RUN:   if (w_last) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Status flags follow the state one cycle later, so done lands WIDTH+1 edges after accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt   <= '0;
         r_quo   <= '0;
         r_rem   <= '0;
         r_dvsr  <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_dbz   <= 1'b0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
      end else begin
         r_busy <= (r_state == S_RUN);
         r_done <= (r_state == S_DONE);
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_dbz   <= w_dvs_zero;
                  r_neg_q <= w_sop & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                  r_neg_r <= w_sop & dividend[WIDTH-1];
                  r_cnt   <= '0;
                  r_dvsr  <= w_dvs_mag;
                  if (w_dvs_zero) begin
                     r_quo <= '1;
                     r_rem <= dividend;
                  end else begin
                     r_quo <= w_dvd_mag;
                     r_rem <= '0;
                  end
               end
            end
            S_RUN: begin
               r_rem <= w_neg ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
               r_quo <= {r_quo[WIDTH-2:0], ~w_neg};
               r_cnt <= r_cnt + CNT_W'(1);
            end
            S_DONE: begin
               if (!r_dbz) begin
                  if (r_neg_q) r_quo <= (~r_quo) + WIDTH'(1);
                  if (r_neg_r) r_rem <= (~r_rem) + WIDTH'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign quotient    = r_quo;
   assign remainder   = r_rem;
   assign busy        = r_busy;
   assign done        = r_done;
   assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_alu_divider.sv
// tb_alu_divider: directed and random checks of alu_divider against an arithmetic model.
// Signed cases are exercised when ALU_DIV_SIGNED_EN is defined.
module tb_alu_divider;

   localparam int unsigned W = 8;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         busy;
   logic         done;
   logic         div_by_zero;
`ifdef ALU_DIV_SIGNED_EN
   logic         signed_op;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   alu_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
`ifdef ALU_DIV_SIGNED_EN
      .signed_op   (signed_op),
`endif
      .dividend    (dividend),
      .divisor     (divisor),
      .quotient    (quotient),
      .remainder   (remainder),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer division; SV int '/' truncates toward zero and '%' follows the dividend.
   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sop,
                                 output logic [W-1:0] q, output logic [W-1:0] r);
      int sa;
      int sb;
      if (b == 0) begin
         q = '1;
         r = a;
      end else if (sop) begin
         sa = $signed(a);
         sb = $signed(b);
         q = W'(sa / sb);
         r = W'(sa % sb);
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   // One operation; optionally pulses a competing start after edge inject_at.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sop,
                         input int inject_at, input string tag);
      logic [W-1:0] eq;
      logic [W-1:0] er;
      int lat;
      int nbusy;
      model(a, b, sop, eq, er);
      dividend = a;
      divisor  = b;
`ifdef ALU_DIV_SIGNED_EN
      signed_op = sop;
`endif
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat   = -1;
      nbusy = int'(busy);
      for (int k = 1; k <= 2 * W + 4; k++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = k;
            break;
         end
         nbusy += int'(busy);
         if (k == inject_at) begin
            start    = 1'b1;
            dividend = 10;
            divisor  = 3;
         end else if (k == inject_at + 1) begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      chk({tag, ".latency"}, lat, (b == 0) ? 1 : W + 1);
      chk({tag, ".quotient"}, quotient, eq);
      chk({tag, ".remainder"}, remainder, er);
      chk({tag, ".div_by_zero"}, div_by_zero, (b == 0) ? 1 : 0);
      chk({tag, ".busy_cycles"}, nbusy, (b == 0) ? 0 : W);
      chk({tag, ".busy_at_done"}, busy, 0);
   endtask

   task automatic count_done(input int cycles, input string tag);
      int nd;
      nd = 0;
      repeat (cycles) begin
         @(posedge clk); #1;
         nd += int'(done);
      end
      chk(tag, nd, 0);
   endtask

   initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rs;
      rst      = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
`ifdef ALU_DIV_SIGNED_EN
      signed_op = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      chk("reset.quotient", quotient, 0);
      chk("reset.remainder", remainder, 0);
      chk("reset.busy", busy, 0);
      chk("reset.done", done, 0);
      chk("reset.div_by_zero", div_by_zero, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      run_op(8'd200, 8'd7, 1'b0, 0, "u200_7");
      chk("u200_7.const_q", quotient, 32'h1C);
      chk("u200_7.const_r", remainder, 32'h04);
      repeat (3) @(posedge clk);
      #1;
      chk("hold.quotient", quotient, 32'h1C);
      chk("hold.remainder", remainder, 32'h04);
      chk("hold.done", done, 0);

      run_op(8'h35, 8'd0, 1'b0, 0, "div0");
      chk("div0.const_q", quotient, 32'hFF);
      run_op(8'd100, 8'd4, 1'b0, 0, "dbz_clear");

      run_op(8'd255, 8'd1, 1'b0, 3, "busy_reject");
      chk("busy_reject.const_q", quotient, 32'hFF);
      count_done(12, "busy_reject.no_extra_done");

      run_op(8'd50, 8'd5, 1'b0, W, "start_in_done");
      count_done(12, "start_in_done.no_extra_done");

      dividend = 8'd100;
      divisor  = 8'd9;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("rst_mid.quotient", quotient, 0);
      chk("rst_mid.remainder", remainder, 0);
      chk("rst_mid.busy", busy, 0);
      chk("rst_mid.done", done, 0);
      chk("rst_mid.div_by_zero", div_by_zero, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      count_done(12, "rst_mid.no_done");
      run_op(8'd100, 8'd9, 1'b0, 0, "after_rst");
      chk("after_rst.const_q", quotient, 32'h0B);
      chk("after_rst.const_r", remainder, 32'h01);

      run_op(8'd3, 8'd9, 1'b0, 0, "small");
      run_op(8'd0, 8'd5, 1'b0, 0, "zero_dvd");
      run_op(8'd255, 8'd255, 1'b0, 0, "b2b_a");
      run_op(8'd254, 8'd128, 1'b0, 0, "b2b_b");

`ifdef ALU_DIV_SIGNED_EN
      run_op(8'h9C, 8'd7, 1'b1, 0, "s_m100_7");
      chk("s_m100_7.const_q", quotient, 32'hF2);
      chk("s_m100_7.const_r", remainder, 32'hFE);
      run_op(8'h80, 8'hFF, 1'b1, 0, "s_m128_m1");
      chk("s_m128_m1.const_q", quotient, 32'h80);
      run_op(8'd100, 8'hF9, 1'b1, 0, "s_100_m7");
      chk("s_100_m7.const_r", remainder, 32'h02);
      run_op(8'h9C, 8'd0, 1'b1, 0, "s_div0");
`endif

      for (int i = 0; i < 40; i++) begin
         ra = W'($urandom);
         rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
`ifdef ALU_DIV_SIGNED_EN
         rs = 1'($urandom_range(0, 1));
`else
         rs = 1'b0;
`endif
         run_op(ra, rb, rs, 0, "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_divider.md
ALU_DIVIDER -- requirements
Module: alu_divider

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, operand/result width in bits; iteration count = WIDTH.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset, with ports as follows (clock and reset first):
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  request a division; sampled only in IDLE
- dividend  input  WIDTH  numerator; sampled with start
- divisor  input  WIDTH  denominator; sampled with start
- quotient  output  WIDTH  result quotient, registered
- remainder  output  WIDTH  result remainder, registered
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when results become valid
- div_by_zero  output  1  set with done when divisor was zero; held until next accepted start

Function
REQ-003 The block SHALL implement a sequential unsigned restoring shift-subtract divider with states IDLE, RUN and DONE.
REQ-004 In IDLE, start=1 at a rising edge SHALL capture dividend and divisor, clear div_by_zero, set busy, and enter RUN (divisor nonzero) or DONE (divisor zero).
REQ-005 RUN SHALL perform exactly WIDTH iterations, one per cycle.
- Each iteration shifts {partial remainder, quotient} left by 1.
- It then trial-subtracts the divisor using a WIDTH+1-bit difference.
- If the difference is non-negative, it keeps the difference and sets the quotient LSB; otherwise it restores.
REQ-006 After the last RUN iteration the block SHALL enter DONE for one cycle.
- In DONE: done=1 and busy=0; quotient/remainder are valid.
- Next state: IDLE.
- Latency: done is high in the cycle beginning WIDTH+1 edges after the accepting edge (9 for WIDTH=8).
REQ-007 Divide by zero SHALL go directly to DONE and produce:
- quotient = all ones
- remainder = dividend
- div_by_zero = 1
- done high on the cycle after acceptance
REQ-008 start SHALL be ignored while in RUN or DONE; no queuing.
REQ-009 quotient, remainder and div_by_zero SHALL hold their values from DONE until the next accepted start.
- During RUN, quotient and remainder are intermediate values and are not valid.
REQ-010 Dividend smaller than divisor SHALL yield quotient=0 and remainder=dividend; dividend=0 SHALL yield 0, 0.
REQ-011 busy SHALL be high in RUN and low in IDLE and DONE.
- start=1 in DONE is not accepted; it must be held or reasserted in IDLE.

Reset
REQ-012 rst=1 SHALL immediately, regardless of clk, force:
- state = IDLE
- quotient = 0, remainder = 0
- busy = 0, done = 0, div_by_zero = 0
REQ-013 Reset during RUN SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL be accepted normally.

Configuration
REQ-014 Macro ALU_DIV_SIGNED_EN SHALL control signed division.
- When defined: add input port signed_op (1 bit, sampled with start).
- With signed_op=1, operands are two's complement; the magnitudes are divided unsigned, then the signs are fixed up in the DONE transition with no added latency.
- Quotient truncates toward zero; remainder takes the sign of the dividend.
- Most-negative divided by -1 yields quotient = most-negative value, remainder 0.
- Signed divide by zero yields quotient all ones and remainder = dividend.
- When undefined: no signed_op port; behaviour is unsigned only.

Verification
REQ-015 Unsigned, WIDTH=8: dividend=200, divisor=7 -> done 9 cycles after start; quotient=0x1C, remainder=0x04, div_by_zero=0.
REQ-016 Divide by zero: dividend=0x35, divisor=0 -> done on next cycle; quotient=0xFF, remainder=0x35, div_by_zero=1.
REQ-017 Busy rejection: start 255/1, then pulse start with 10/3 during RUN -> single done; quotient=0xFF, remainder=0x00; busy high for exactly 8 cycles.
REQ-018 Reset mid-op: start 100/9, assert rst at iteration 4 -> outputs 0 immediately, no done; then 100/9 -> quotient=0x0B, remainder=0x01.
REQ-019 Boundaries: 3/9 -> quotient 0x00, remainder 0x03; 0/5 -> 0x00, 0x00; back-to-back starts asserted in IDLE right after DONE are both serviced.
REQ-020 With ALU_DIV_SIGNED_EN, signed_op=1:
- -100/7 -> quotient=0xF2, remainder=0xFE.
- -128/-1 -> quotient=0x80, remainder=0x00.
- 100/-7 -> quotient=0xF2, remainder=0x02.
